pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the RV32I 5-stage core. It merges the hazard unit's load-use stall and branch flush with two multi-cycle events: an iterative MUL/DIV unit occupying E, and data-memory wait states in M. It produces per-stage pipeline-register enables and bubble/flush controls, plus the MDU start pulse. It also keeps a saturating stall-cycle counter and a sticky MDU timeout flag.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced abort (≥2)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_hz  in  1  load-use stall request from hazard unit
flush_br  in  1  taken branch/jump resolved in E
mdu_op_E  in  1  instruction in E is MUL/DIV
mdu_done  in  1  MDU result valid (1-cycle pulse)
dmem_req_M  in  1  load/store in M
dmem_ready  in  1  data memory accepts/returns this cycle
en_F  out  1  PC register enable
en_D  out  1  F/D register enable
en_E  out  1  D/E register enable
en_M  out  1  E/M register enable
en_W  out  1  M/W register enable
flush_D  out  1  clear F/D register to NOP
flush_E  out  1  clear D/E register to NOP
flush_M  out  1  clear E/M register to NOP
mdu_go  out  1  start pulse to MDU
mdu_timeout  out  1  sticky: MDU abort occurred
stall_cycles  out  CNT_W  count of cycles with en_F=0

Behaviour:
- One clock domain, clk. reset is synchronous and active-high. All state updates on the rising edge.
- Outputs en_*, flush_*, mdu_go are combinational from state and inputs (same-cycle stall). stall_cycles and mdu_timeout are registered.
- While reset=1: en_*=0, flush_D=flush_E=flush_M=1, mdu_go=0. Next state RUN; stall_cycles=0, mdu_timeout=0, timeout counter=0.
- Default (no condition active): all en_*=1, all flush_*=0, mdu_go=0.
- States: RUN, MDU_BUSY.
- Priority, highest first, in any state:
  1. mem_wait = dmem_req_M & ~dmem_ready. All en_*=0, no flush, mdu_go=0, state held. The timeout counter does not advance.
  2. RUN & mdu_op_E. mdu_go=1 for exactly this cycle. en_F=en_D=en_E=0. en_M=en_W=1 with flush_M=1 (bubble into M). Next state MDU_BUSY; timeout counter=0.
  3. RUN & flush_br. flush_D=flush_E=1, all en_*=1.
  4. RUN & stall_hz. en_F=en_D=0, flush_E=1, en_E=en_M=en_W=1.
- MDU_BUSY (no mem_wait):
  - mdu_done=0: en_F/D/E=0, flush_M=1, en_M=en_W=1. Timeout counter +1.
  - mdu_done=1: default outputs (E advances with result); next state RUN.
  - If the counter reaches MDU_TIMEOUT-1 without done: behave as done; set mdu_timeout=1 (cleared only by reset); next state RUN.
  - flush_br and stall_hz are ignored. mdu_go stays 0.
- mdu_done in RUN is ignored.
- An mdu_op_E that is blocked by mem_wait is issued on the first cycle mem_wait drops. mdu_go is therefore asserted only once per instruction.
- In RUN with flush_br=1 and mdu_op_E=1, the MDU issue wins: it is the same E instruction, so a branch cannot be present.
- stall_cycles increments by 1 on each cycle where en_F=0 and reset=0. It saturates at 2^CNT_W-1.

Test Plan:
- Load-use: stall_hz=1 for 1 cycle in RUN -> en_F=en_D=0, flush_E=1, en_M=1; stall_cycles 0->1.
- Branch: flush_br=1 with stall_hz=1 -> flush_D=flush_E=1, all en=1, stall_cycles unchanged.
- MUL: mdu_op_E=1, mdu_done 4 cycles after mdu_go -> mdu_go single pulse; en_F/D/E=0 and flush_M=1 for 4 cycles; done cycle all en=1; state RUN; stall_cycles=4.
- Mem wait during MDU_BUSY: dmem_ready=0 for 3 cycles -> all en=0, flush_M=0; completion delayed 3 cycles; no second mdu_go.
- Deferred issue: mdu_op_E=1 while mem_wait 2 cycles -> mdu_go=0 both cycles, mdu_go=1 on cycle 3.
- Timeout with MDU_TIMEOUT=8 and no mdu_done -> returns to RUN after 8 cycles in MDU_BUSY; mdu_timeout=1 and stays set until reset.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: stalls, flushes, MDU issue/wait, stall stats
module pipe_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_hz,
    input  logic             flush_br,
    input  logic             mdu_op_E,
    input  logic             mdu_done,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             en_F,
    output logic             en_D,
    output logic             en_E,
    output logic             en_M,
    output logic             en_W,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             mdu_go,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TW-1:0]    TO_LAST = TW'(MDU_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_wait;

    assign mem_wait     = dmem_req_M & ~dmem_ready;
    assign mdu_timeout  = timeout_q;
    assign stall_cycles = cnt_q;

    // Stage controls and next state, resolved in priority order; memory wait freezes everything
    always_comb begin
        en_F      = 1'b1;
        en_D      = 1'b1;
        en_E      = 1'b1;
        en_M      = 1'b1;
        en_W      = 1'b1;
        flush_D   = 1'b0;
        flush_E   = 1'b0;
        flush_M   = 1'b0;
        mdu_go    = 1'b0;
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        if (reset) begin
            en_F      = 1'b0;
            en_D      = 1'b0;
            en_E      = 1'b0;
            en_M      = 1'b0;
            en_W      = 1'b0;
            flush_D   = 1'b1;
            flush_E   = 1'b1;
            flush_M   = 1'b1;
            state_d   = S_RUN;
            tcnt_d    = '0;
            timeout_d = 1'b0;
        end else if (mem_wait) begin
            en_F = 1'b0;
            en_D = 1'b0;
            en_E = 1'b0;
            en_M = 1'b0;
            en_W = 1'b0;
        end else if (state_q == S_RUN) begin
            // MDU issue outranks a branch: the E slot holds the MUL/DIV, not a branch
            if (mdu_op_E) begin
                mdu_go  = 1'b1;
                en_F    = 1'b0;
                en_D    = 1'b0;
                en_E    = 1'b0;
                flush_M = 1'b1;
                state_d = S_BUSY;
                tcnt_d  = '0;
            end else if (flush_br) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (stall_hz) begin
                en_F    = 1'b0;
                en_D    = 1'b0;
                flush_E = 1'b1;
            end
        end else begin
            // MDU busy: hold F/D/E and bubble M until done or the watchdog expires
            if (mdu_done) begin
                state_d = S_RUN;
            end else if (tcnt_q == TO_LAST) begin
                state_d   = S_RUN;
                timeout_d = 1'b1;
            end else begin
                en_F    = 1'b0;
                en_D    = 1'b0;
                en_E    = 1'b0;
                flush_M = 1'b1;
                tcnt_d  = tcnt_q + TW'(1);
            end
        end
    end

    // Saturating count of cycles with the PC held
    always_comb begin
        cnt_d = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (!en_F && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset values come through the _d logic
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        tcnt_q    <= tcnt_d;
        timeout_q <= timeout_d;
        cnt_q     <= cnt_d;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall_hz, flush_br, mdu_op_E, mdu_done, dmem_req_M, dmem_ready;
    logic       en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, flush_M, mdu_go, mdu_timeout;
    logic [3:0] stall_cycles;
    int         checks = 0;
    int         errors = 0;

    // {en_F,en_D,en_E,en_M,en_W, flush_D,flush_E,flush_M, mdu_go}
    localparam logic [8:0] O_DEF   = 9'b11111_000_0;
    localparam logic [8:0] O_RST   = 9'b00000_111_0;
    localparam logic [8:0] O_ISSUE = 9'b00011_001_1;
    localparam logic [8:0] O_BUSY  = 9'b00011_001_0;
    localparam logic [8:0] O_BR    = 9'b11111_110_0;
    localparam logic [8:0] O_LU    = 9'b00111_010_0;
    localparam logic [8:0] O_MW    = 9'b00000_000_0;

    pipe_ctrl #(.MDU_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall_hz(stall_hz), .flush_br(flush_br),
        .mdu_op_E(mdu_op_E), .mdu_done(mdu_done), .dmem_req_M(dmem_req_M),
        .dmem_ready(dmem_ready), .en_F(en_F), .en_D(en_D), .en_E(en_E),
        .en_M(en_M), .en_W(en_W), .flush_D(flush_D), .flush_E(flush_E),
        .flush_M(flush_M), .mdu_go(mdu_go), .mdu_timeout(mdu_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs already applied for this cycle: check combinational outputs, then advance one clock
    task automatic cyc(input string tag, input logic [8:0] exp);
        #2;
        check(tag, {23'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, flush_M, mdu_go},
              {23'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_hz = 0; flush_br = 0; mdu_op_E = 0; mdu_done = 0;
        dmem_req_M = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc("reset_out", O_RST);
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();
        check("rst_cnt", 32'(stall_cycles), 32'd0);
        check("rst_to", 32'(mdu_timeout), 32'd0);
        cyc("idle", O_DEF);
        check("idle_cnt", 32'(stall_cycles), 32'd0);

        // Load-use stall
        stall_hz = 1;
        cyc("loaduse", O_LU);
        stall_hz = 0;
        check("lu_cnt", 32'(stall_cycles), 32'd1);

        // Branch wins over stall
        flush_br = 1; stall_hz = 1;
        cyc("branch", O_BR);
        idle_inputs();
        check("br_cnt", 32'(stall_cycles), 32'd1);

        // mdu_done in RUN is ignored
        mdu_done = 1;
        cyc("done_run", O_DEF);
        mdu_done = 0;

        // MUL: issue, 3 busy cycles, done on the 4th after go
        do_reset();
        mdu_op_E = 1; flush_br = 1;
        cyc("mul_issue", O_ISSUE);
        flush_br = 0;
        cyc("mul_busy1", O_BUSY);
        stall_hz = 1; flush_br = 1;
        cyc("mul_busy2_ign", O_BUSY);
        stall_hz = 0; flush_br = 0;
        cyc("mul_busy3", O_BUSY);
        mdu_done = 1;
        cyc("mul_done", O_DEF);
        idle_inputs();
        check("mul_cnt", 32'(stall_cycles), 32'd4);
        cyc("mul_back_run", O_DEF);

        // Memory wait inside MDU_BUSY
        do_reset();
        mdu_op_E = 1;
        cyc("mw_issue", O_ISSUE);
        mdu_op_E = 0;
        cyc("mw_busy1", O_BUSY);
        dmem_req_M = 1; dmem_ready = 0; mdu_done = 1;
        for (int i = 0; i < 3; i++) cyc("mw_hold", O_MW);
        dmem_ready = 1; mdu_done = 0;
        cyc("mw_busy2", O_BUSY);
        cyc("mw_busy3", O_BUSY);
        mdu_done = 1;
        cyc("mw_done", O_DEF);
        idle_inputs();
        check("mw_cnt", 32'(stall_cycles), 32'd7);
        cyc("mw_run", O_DEF);

        // Deferred issue behind memory wait
        do_reset();
        mdu_op_E = 1; dmem_req_M = 1; dmem_ready = 0;
        cyc("def_wait1", O_MW);
        cyc("def_wait2", O_MW);
        dmem_ready = 1;
        cyc("def_issue", O_ISSUE);
        cyc("def_no_rego", O_BUSY);
        mdu_done = 1;
        cyc("def_done", O_DEF);
        idle_inputs();
        check("def_cnt", 32'(stall_cycles), 32'd4);

        // Watchdog: 7 busy cycles, then forced return on the 8th
        do_reset();
        mdu_op_E = 1;
        cyc("to_issue", O_ISSUE);
        mdu_op_E = 0;
        for (int i = 0; i < 7; i++) cyc("to_busy", O_BUSY);
        check("to_pre", 32'(mdu_timeout), 32'd0);
        cyc("to_fire", O_DEF);
        check("to_set", 32'(mdu_timeout), 32'd1);
        check("to_cnt", 32'(stall_cycles), 32'd8);
        cyc("to_run", O_DEF);
        cyc("to_run2", O_DEF);
        check("to_sticky", 32'(mdu_timeout), 32'd1);
        do_reset();
        check("to_clear", 32'(mdu_timeout), 32'd0);

        // Counter saturation at 15
        stall_hz = 1;
        for (int i = 0; i < 15; i++) cyc("sat_lu", O_LU);
        check("sat_15", 32'(stall_cycles), 32'd15);
        cyc("sat_lu_more", O_LU);
        cyc("sat_lu_more", O_LU);
        check("sat_hold", 32'(stall_cycles), 32'd15);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
